// File: rtl/riscv_instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
//   resp_state_e     : grant FSM states
//   MAX_RESP_LATENCY : largest supported grant-to-rvalid latency
//   in_region()      : 33-bit range check of a byte address against a region
package riscv_instr_mem_pkg;

  localparam int MAX_RESP_LATENCY = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } resp_state_e;

  // Region is [base, base + 4*2^aw). The 33-bit arithmetic keeps a region that
  // ends exactly at 4 GiB from wrapping to zero.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + (33'd4 << aw);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/riscv_resp_pipe.sv
// Fixed-latency response pipe. A push enters the valid shift register and
// emerges DEPTH cycles later. The data word arrives one cycle after its push
// (single-cycle SRAM read), so DEPTH==1 passes it straight through and
// DEPTH>1 registers it and walks it alongside its valid bit.
//   clk, rst_n : clock, async active-low reset
//   push       : start a response (one per grant)
//   push_data  : read data, valid the cycle after push
//   out_valid  : response valid, DEPTH cycles after push
//   out_data   : response data, forced to 0 when out_valid is low
//   busy       : any response in flight
module riscv_resp_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_tail;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor; blocking here would collapse the
  // shift register into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  generate
    if (DEPTH == 1) begin : g_direct
      assign data_tail = push_data;
    end else begin : g_regs
      // data_q[i] travels alongside valid_q[i+1].
      logic [WIDTH-1:0] data_q [DEPTH-1];

      // NOTE: the data stages carry no reset. Their contents only reach the
      // output while the matching valid bit is set, and valids are reset, so
      // stale data is never observable.
      always_ff @(posedge clk) begin
        if (valid_q[0]) data_q[0] <= push_data;
        for (int i = 1; i < DEPTH - 1; i++) begin
          if (valid_q[i]) data_q[i] <= data_q[i-1];
        end
      end

      assign data_tail = data_q[DEPTH-2];
    end
  endgenerate

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = out_valid ? data_tail : '0;
  assign busy      = |valid_q;

endmodule

// File: rtl/riscv_instr_mem_responder.sv
// Responder end of the instruction fetch interface, in front of a
// single-port SRAM with a fixed one-cycle read. Inserts programmable grant
// wait-states, delivers responses after RESP_LATENCY cycles, and flags
// fetches outside the SRAM region on instr_err_pmp_o.
//   clk, rst_n       : clock, async active-low reset
//   instr_req_i      : fetch request
//   instr_addr_i     : byte address (bits [1:0] ignored), may change while waiting
//   instr_gnt_o      : request accepted this cycle
//   instr_err_pmp_o  : request to an address outside the region (never with gnt)
//   instr_rvalid_o   : response valid, one per grant, in order
//   instr_rdata_o    : response data, 0 when rvalid is low
//   gnt_stall_i      : wait-states before each grant (0 = same-cycle grant)
//   mem_req_o        : SRAM read enable (same as instr_gnt_o)
//   mem_addr_o       : SRAM word address
//   mem_rdata_i      : SRAM read data, valid the cycle after mem_req_o
//   busy_o           : FSM waiting or any response in flight
module riscv_instr_mem_responder
  import riscv_instr_mem_pkg::*;
#(
  parameter int          RDATA_WIDTH    = 32,
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_8000,
  parameter int          RESP_LATENCY   = 1,
  parameter int          STALL_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_req_i,
  input  logic [31:0]               instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_err_pmp_o,
  output logic                      instr_rvalid_o,
  output logic [RDATA_WIDTH-1:0]    instr_rdata_o,
  input  logic [STALL_WIDTH-1:0]    gnt_stall_i,
  output logic                      mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [RDATA_WIDTH-1:0]    mem_rdata_i,
  output logic                      busy_o
);

  // The word offset is a true subtraction, so any word-aligned base works;
  // only word alignment and a sane latency are enforced.
  generate
    if (RESP_LATENCY < 1 || RESP_LATENCY > MAX_RESP_LATENCY) begin : g_bad_latency
      $error("RESP_LATENCY must be in 1..%0d", MAX_RESP_LATENCY);
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("BASE_ADDR must be word aligned");
    end
    if (MEM_ADDR_WIDTH < 1 || MEM_ADDR_WIDTH > 30) begin : g_bad_aw
      $error("MEM_ADDR_WIDTH must be in 1..30");
    end
  endgenerate

  resp_state_e            state_q, state_d;
  logic [STALL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   in_range;
  logic                   fetch_ok;
  logic                   grant;
  logic                   pipe_busy;

  assign in_range        = in_region(instr_addr_i, BASE_ADDR, MEM_ADDR_WIDTH);
  assign fetch_ok        = instr_req_i & in_range;
  assign instr_err_pmp_o = instr_req_i & ~in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block is given a default before the case, so
  // paths that do not mention a signal cannot infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_ok) begin
          if (gnt_stall_i == '0) begin
            grant = 1'b1;
          end else begin
            // Current cycle is the first wait-state.
            cnt_d   = gnt_stall_i - STALL_WIDTH'(1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A dropped request or a redirect out of range abandons the wait.
        if (!fetch_ok) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - STALL_WIDTH'(1);
        end else begin
          grant   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign instr_gnt_o = grant;
  assign mem_req_o   = grant;

  // Bits [1:0] of a word-aligned base are zero, so no borrow crosses into
  // bit 2 and the sliced subtraction equals (addr - base) >> 2 in range.
  assign mem_addr_o = instr_addr_i[MEM_ADDR_WIDTH+1:2] - BASE_ADDR[MEM_ADDR_WIDTH+1:2];

  riscv_resp_pipe #(
    .WIDTH (RDATA_WIDTH),
    .DEPTH (RESP_LATENCY)
  ) u_resp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (mem_rdata_i),
    .out_valid (instr_rvalid_o),
    .out_data  (instr_rdata_o),
    .busy      (pipe_busy)
  );

  assign busy_o = (state_q != IDLE) | pipe_busy;

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Self-checking bench: a latency-1 instance driven from a per-cycle vector
// table, and a latency-3 instance driven by hand-written sequences for the
// pipelined and reset-mid-flight cases. Responses are checked by scoreboards
// holding expected data and the cycle it is due.
module tb_riscv_instr_mem_responder;

  localparam int AW = 14;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  stall;
    logic        gnt;
    logic        err;
    logic [13:0] maddr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Latency-1 instance
  logic        req1, gnt1, err1, rvalid1, mreq1, busy1;
  logic [31:0] addr1, rdata1, mrdata1;
  logic [3:0]  stall1;
  logic [13:0] maddr1;
  // Latency-3 instance
  logic        req3, gnt3, err3, rvalid3, mreq3, busy3;
  logic [31:0] addr3, rdata3, mrdata3;
  logic [3:0]  stall3;
  logic [13:0] maddr3;

  exp_t q1[$];
  exp_t q3[$];
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: word k holds 0xA000_0000 + k, one-cycle read.
  initial begin
    mrdata1 = '0;
    mrdata3 = '0;
  end
  always @(posedge clk) if (mreq1) mrdata1 <= 32'hA000_0000 + 32'(maddr1);
  always @(posedge clk) if (mreq3) mrdata3 <= 32'hA000_0000 + 32'(maddr3);

  riscv_instr_mem_responder #(
    .RDATA_WIDTH(32), .MEM_ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_8000),
    .RESP_LATENCY(1), .STALL_WIDTH(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req1), .instr_addr_i(addr1), .instr_gnt_o(gnt1),
    .instr_err_pmp_o(err1), .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1),
    .gnt_stall_i(stall1), .mem_req_o(mreq1), .mem_addr_o(maddr1),
    .mem_rdata_i(mrdata1), .busy_o(busy1)
  );

  riscv_instr_mem_responder #(
    .RDATA_WIDTH(32), .MEM_ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_8000),
    .RESP_LATENCY(3), .STALL_WIDTH(4)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(req3), .instr_addr_i(addr3), .instr_gnt_o(gnt3),
    .instr_err_pmp_o(err3), .instr_rvalid_o(rvalid3), .instr_rdata_o(rdata3),
    .gnt_stall_i(stall3), .mem_req_o(mreq3), .mem_addr_o(maddr3),
    .mem_rdata_i(mrdata3), .busy_o(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic [3:0] stall,
                              input logic gnt, input logic err, input logic [13:0] maddr);
    vec_t v;
    v.req = req; v.addr = addr; v.stall = stall;
    v.gnt = gnt; v.err = err; v.maddr = maddr;
    return v;
  endfunction

  // Scoreboards: a response is expected exactly in its due cycle; any other
  // cycle must show rvalid low and rdata zero.
  always @(negedge clk) begin
    if (q1.size() != 0 && q1[0].due == cyc) begin
      check("rvalid_l1", 32'(rvalid1), 32'd1);
      check("rdata_l1", rdata1, q1[0].data);
      void'(q1.pop_front());
    end else begin
      check("quiet_rvalid_l1", 32'(rvalid1), 32'd0);
      check("quiet_rdata_l1", rdata1, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (q3.size() != 0 && q3[0].due == cyc) begin
      check("rvalid_l3", 32'(rvalid3), 32'd1);
      check("rdata_l3", rdata3, q3[0].data);
      void'(q3.pop_front());
    end else begin
      check("quiet_rvalid_l3", 32'(rvalid3), 32'd0);
      check("quiet_rdata_l3", rdata3, 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    req1 = 1'b0; addr1 = '0; stall1 = '0;
    req3 = 1'b0; addr3 = '0; stall3 = '0;

    //          req   addr          stall gnt  err  maddr
    // Stall 0, back-to-back grants
    vecs.push_back(mk(1'b1, 32'h0000_8000, 4'd0, 1'b1, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8004, 4'd0, 1'b1, 1'b0, 14'h0001));
    vecs.push_back(mk(1'b1, 32'h0000_8008, 4'd0, 1'b1, 1'b0, 14'h0002));
    vecs.push_back(mk(1'b1, 32'h0000_800C, 4'd0, 1'b1, 1'b0, 14'h0003));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 14'h0000));
    // Stall 2: grant on third cycle; stall ignored once waiting
    vecs.push_back(mk(1'b1, 32'h0000_8010, 4'd2, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8010, 4'd0, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8010, 4'd0, 1'b1, 1'b0, 14'h0004));
    vecs.push_back(mk(1'b0, 32'h0000_8010, 4'd0, 1'b0, 1'b0, 14'h0000));
    // Range edges
    vecs.push_back(mk(1'b1, 32'h0000_7FFC, 4'd0, 1'b0, 1'b1, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0001_7FFC, 4'd0, 1'b1, 1'b0, 14'h3FFF));
    vecs.push_back(mk(1'b1, 32'h0001_8000, 4'd0, 1'b0, 1'b1, 14'h0000));
    vecs.push_back(mk(1'b0, 32'h0001_8000, 4'd0, 1'b0, 1'b0, 14'h0000));
    // Redirect while waiting (stall 3)
    vecs.push_back(mk(1'b1, 32'h0000_8000, 4'd3, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8000, 4'd0, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8100, 4'd0, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8100, 4'd0, 1'b1, 1'b0, 14'h0040));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 14'h0000));
    // Request dropped while waiting, then immediate grant from IDLE
    vecs.push_back(mk(1'b1, 32'h0000_8020, 4'd2, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b0, 32'h0000_8020, 4'd0, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8020, 4'd0, 1'b1, 1'b0, 14'h0008));
    // Out-of-range redirect while waiting abandons the wait
    vecs.push_back(mk(1'b1, 32'h0000_8024, 4'd1, 1'b0, 1'b0, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_0004, 4'd0, 1'b0, 1'b1, 14'h0000));
    vecs.push_back(mk(1'b1, 32'h0000_8024, 4'd0, 1'b1, 1'b0, 14'h0009));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 14'h0000));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", 32'(gnt1), 32'd0);
    check("reset_err", 32'(err1), 32'd0);
    check("reset_mem_req", 32'(mreq1), 32'd0);
    check("reset_busy_l1", 32'(busy1), 32'd0);
    check("reset_busy_l3", 32'(busy3), 32'd0);
    step();
    rst_n = 1'b1;

    // Table-driven latency-1 vectors, one per cycle
    foreach (vecs[i]) begin
      step();
      req1 = vecs[i].req; addr1 = vecs[i].addr; stall1 = vecs[i].stall;
      @(negedge clk);
      check($sformatf("gnt[%0d]", i), 32'(gnt1), 32'(vecs[i].gnt));
      check($sformatf("err_pmp[%0d]", i), 32'(err1), 32'(vecs[i].err));
      check($sformatf("mem_req[%0d]", i), 32'(mreq1), 32'(vecs[i].gnt));
      if (vecs[i].gnt) begin
        check($sformatf("mem_addr[%0d]", i), 32'(maddr1), 32'(vecs[i].maddr));
        q1.push_back('{data: 32'hA000_0000 + 32'(vecs[i].maddr), due: cyc + 1});
      end
    end
    step();
    req1 = 1'b0;

    // Latency 3: four back-to-back grants, busy while any is in flight
    for (int k = 0; k < 4; k++) begin
      step();
      req3 = 1'b1; addr3 = 32'h0000_8000 + 32'(4 * k); stall3 = '0;
      @(negedge clk);
      check("gnt_l3", 32'(gnt3), 32'd1);
      if (k > 0) check("busy_l3_issue", 32'(busy3), 32'd1);
      q3.push_back('{data: 32'hA000_0000 + 32'(k), due: cyc + 3});
    end
    for (int c = 4; c < 8; c++) begin
      step();
      req3 = 1'b0;
      @(negedge clk);
      check($sformatf("busy_l3_drain[%0d]", c), 32'(busy3), (c < 7) ? 32'd1 : 32'd0);
    end

    // Reset with two responses in flight: none may appear afterwards
    for (int k = 0; k < 2; k++) begin
      step();
      req3 = 1'b1; addr3 = 32'h0000_8040 + 32'(4 * k);
      @(negedge clk);
      check("gnt_l3_pre_reset", 32'(gnt3), 32'd1);
    end
    step();
    req3 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_gnt_l3", 32'(gnt3), 32'd0);
    check("rst_mem_req_l3", 32'(mreq3), 32'd0);
    check("rst_err_l3", 32'(err3), 32'd0);
    check("rst_busy_l3", 32'(busy3), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_rvalid_l3", 32'(rvalid3), 32'd0);
      check("post_rst_busy_l3", 32'(busy3), 32'd0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drained_l1", 32'(q1.size()), 32'd0);
    check("drained_l3", 32'(q3.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
